// File: rtl/parameters.sv
// Shared accelerator parameters, plus the state type of the PE row drain engine.
package parameters;

    localparam int ACC_DATA_WIDTH = 32;
    localparam int ACT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        DR_IDLE,
        DR_SHIFT,
        DR_GAP,
        DR_FLUSH,
        DR_DONE
    } drain_state_t;

endpackage

// File: rtl/pe_row_drain_if.sv
// Valid/ready write port from the row drain engine into the output buffer.
interface pe_row_drain_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_WIDTH = 32
) ();

    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_WIDTH-1:0] wr_data;

    modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);

endinterface

// File: rtl/drain_packer.sv
// Packs chain samples into words, holds one word for the write port and
// stalls the chain when a finished word has nowhere to go.
module drain_packer #(
    parameter int ACC_DATA_WIDTH = 32,
    parameter int ACT_DATA_WIDTH = 8,
    parameter int WORD_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_req,
    input  logic                      raw_mode,
    input  logic [ACC_DATA_WIDTH-1:0] sample,
    input  logic [ADDR_WIDTH-1:0]     word_addr,
    output logic                      shift_en,
    output logic                      drained,
    pe_row_drain_if.master            wr
);

    localparam int LANES = WORD_WIDTH / ACT_DATA_WIDTH;
    localparam int LCW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int KEEP  = WORD_WIDTH - ACT_DATA_WIDTH;

    logic [LCW-1:0]        lane_q, lane_d;
    logic [KEEP-1:0]       pack_q, pack_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic [WORD_WIDTH-1:0] packed_word;
    logic                  completes;
    logic                  accept;

    always_comb begin
        completes   = raw_mode || (lane_q == LCW'(LANES - 1));
        accept      = valid_q && wr.wr_ready;
        shift_en    = sample_req && !(completes && valid_q && !wr.wr_ready);
        drained     = (lane_q == '0) && (!valid_q || wr.wr_ready);
        packed_word = {pack_q, sample[ACT_DATA_WIDTH-1:0]};
    end

    // The earliest sample ends up in the top lane once the word is full.
    always_comb begin
        lane_d  = lane_q;
        pack_d  = pack_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (accept) begin
            valid_d = 1'b0;
            addr_d  = '0;
            data_d  = '0;
        end
        if (shift_en) begin
            if (completes) begin
                valid_d = 1'b1;
                addr_d  = word_addr;
                data_d  = raw_mode ? sample : packed_word;
                pack_d  = '0;
                lane_d  = '0;
            end else begin
                pack_d = packed_word[KEEP-1:0];
                lane_d = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q  <= '0;
            pack_q  <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign wr.wr_valid = valid_q;
    assign wr.wr_addr  = addr_q;
    assign wr.wr_data  = data_q;

endmodule

// File: rtl/pe_row_drain.sv
// Readout engine at the end of the PE neighbour chain: shifts rows out one PE
// per cycle and writes them, packed or raw, to the output buffer.
module pe_row_drain #(
    parameter int NUM_PE         = 16,
    parameter int ACC_DATA_WIDTH = parameters::ACC_DATA_WIDTH,
    parameter int ACT_DATA_WIDTH = parameters::ACT_DATA_WIDTH,
    parameter int WORD_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [7:0]                num_rows,
    input  logic                      raw_mode,
    input  logic [ACC_DATA_WIDTH-1:0] chain_in,
    output logic                      shift_en,
    output logic [7:0]                row_sel,
    output logic                      busy,
    output logic                      done,
    pe_row_drain_if.master            wr
);

    import parameters::*;

    localparam int LANES = WORD_WIDTH / ACT_DATA_WIDTH;
    localparam int CW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    generate
        if (WORD_WIDTH != ACC_DATA_WIDTH) begin : g_bad_word_width
            $error("pe_row_drain: WORD_WIDTH must equal ACC_DATA_WIDTH");
        end
        if ((NUM_PE % LANES) != 0) begin : g_bad_lane_split
            $error("pe_row_drain: NUM_PE must be a multiple of LANES for packed mode");
        end
    endgenerate

    drain_state_t          state_q, state_d;
    logic [7:0]            row_q, row_d;
    logic [7:0]            rows_q, rows_d;
    logic                  raw_q, raw_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [CW-1:0]         samp_q, samp_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  sample_req;
    logic                  drained;
    int                    wpr;
    int                    word_idx;

    // Words leave a row highest address first so memory ends up in PE order.
    always_comb begin
        wpr        = raw_q ? NUM_PE : NUM_PE / LANES;
        word_idx   = raw_q ? int'(samp_q) : int'(samp_q) / LANES;
        word_addr  = row_base_q + ADDR_WIDTH'(wpr - 1 - word_idx);
        sample_req = (state_q == DR_SHIFT);
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        rows_d     = rows_q;
        raw_d      = raw_q;
        row_base_d = row_base_q;
        samp_d     = samp_q;
        case (state_q)
            DR_IDLE: begin
                if (start) begin
                    rows_d     = num_rows;
                    raw_d      = raw_mode;
                    row_base_d = base_addr;
                    row_d      = '0;
                    samp_d     = '0;
                    state_d    = (num_rows == 8'd0) ? DR_FLUSH : DR_SHIFT;
                end
            end
            DR_SHIFT: begin
                if (shift_en) begin
                    if (samp_q == CW'(NUM_PE - 1)) begin
                        samp_d  = '0;
                        state_d = (row_q == rows_q - 8'd1) ? DR_FLUSH : DR_GAP;
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end
            DR_GAP: begin
                row_d      = row_q + 8'd1;
                row_base_d = row_base_q + ADDR_WIDTH'(wpr);
                state_d    = DR_SHIFT;
            end
            DR_FLUSH: begin
                if (drained) state_d = DR_DONE;
            end
            DR_DONE: begin
                row_d   = '0;
                state_d = DR_IDLE;
            end
            default: state_d = DR_IDLE;
        endcase
        busy_d = state_d inside {DR_SHIFT, DR_GAP, DR_FLUSH};
        done_d = (state_d == DR_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DR_IDLE;
            row_q      <= '0;
            rows_q     <= '0;
            raw_q      <= 1'b0;
            row_base_q <= '0;
            samp_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            rows_q     <= rows_d;
            raw_q      <= raw_d;
            row_base_q <= row_base_d;
            samp_q     <= samp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    drain_packer #(
        .ACC_DATA_WIDTH (ACC_DATA_WIDTH),
        .ACT_DATA_WIDTH (ACT_DATA_WIDTH),
        .WORD_WIDTH     (WORD_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .sample_req (sample_req),
        .raw_mode   (raw_q),
        .sample     (chain_in),
        .word_addr  (word_addr),
        .shift_en   (shift_en),
        .drained    (drained),
        .wr         (wr)
    );

    assign row_sel = row_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pe_row_drain.sv
// Scoreboard bench for pe_row_drain: a PE-row chain model feeds the DUT and a
// monitor compares every accepted write against the expected memory stream.
module tb_pe_row_drain;

    localparam int NUM_PE = 8;
    localparam int AW     = 16;
    localparam int WW     = 32;
    localparam int LANES  = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [7:0]    num_rows;
    logic          raw_mode;
    logic [31:0]   chain_in;
    logic          shift_en;
    logic [7:0]    row_sel;
    logic          busy;
    logic          done;

    int  n_vec    = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    wr_t exp_q[$];

    logic [31:0] row_vals [4][NUM_PE];
    int          ptr [4];

    int done_cyc, first_valid_cyc, gap_cnt;
    bit shift_seen, valid_seen, unstable, busy1, shift1, shift8;
    bit zero_after_reset, valid_after_reset, shift_after_reset;

    pe_row_drain_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) wr_if ();

    always #5 clk = ~clk;

    pe_row_drain #(
        .NUM_PE     (NUM_PE),
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .raw_mode  (raw_mode),
        .chain_in  (chain_in),
        .shift_en  (shift_en),
        .row_sel   (row_sel),
        .busy      (busy),
        .done      (done),
        .wr        (wr_if)
    );

    // PE row model: each shift pulse moves the selected row one PE closer to the output.
    always_comb begin
        chain_in = '0;
        if (row_sel < 8'd4 && ptr[row_sel[1:0]] < NUM_PE)
            chain_in = row_vals[row_sel[1:0]][NUM_PE - 1 - ptr[row_sel[1:0]]];
    end

    always @(posedge clk) begin
        if (start && !busy && !reset) begin
            for (int i = 0; i < 4; i++) ptr[i] <= 0;
        end else if (shift_en && row_sel < 8'd4) begin
            ptr[row_sel[1:0]] <= ptr[row_sel[1:0]] + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: a write is accepted on the edge after a cycle with valid && ready.
    always begin : monitor
        wr_t e;
        @(negedge clk);
        #1;
        if (!reset && wr_if.wr_valid && wr_if.wr_ready) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL unexpected_write: got addr 0x%04h data 0x%08h, expected no write",
                         wr_if.wr_addr, wr_if.wr_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wr_addr", 32'(wr_if.wr_addr), 32'(e.addr));
                checkOutput("wr_data", wr_if.wr_data, e.data);
            end
        end
    end

    // Issues a start pulse and queues the memory words the drain should produce.
    task automatic applyStimulus(input bit mode, input logic [7:0] rows, input logic [AW-1:0] base,
                                 input bit rdy);
        wr_t e;
        int  wpr;
        wpr = mode ? NUM_PE : NUM_PE / LANES;
        @(negedge clk);
        for (int r = 0; r < int'(rows); r++) begin
            for (int w = wpr - 1; w >= 0; w--) begin
                e.addr = base + AW'(r * wpr + w);
                if (mode) begin
                    e.data = row_vals[r][w];
                end else begin
                    e.data = '0;
                    for (int l = 0; l < LANES; l++)
                        e.data[8*l +: 8] = row_vals[r][w*LANES + l][7:0];
                end
                exp_q.push_back(e);
            end
        end
        base_addr       = base;
        num_rows        = rows;
        raw_mode        = mode;
        start           = 1'b1;
        wr_if.wr_ready  = rdy;
    endtask

    // ready_mode: 0 always ready, 1 stall cycles 5..10, 2 random, 3 never ready.
    task automatic run_drain(input bit mode, input logic [7:0] rows, input logic [AW-1:0] base,
                             input int ready_mode, input int restart_cyc, input int reset_cyc);
        bit            holding;
        logic [AW-1:0] held_addr;
        logic [WW-1:0] held_data;
        int            low_run;
        int            limit;
        applyStimulus(mode, rows, base, ready_mode != 3);
        done_cyc = -1; first_valid_cyc = -1; gap_cnt = 0; low_run = 0;
        shift_seen = 0; valid_seen = 0; unstable = 0; holding = 0;
        busy1 = 0; shift1 = 0; shift8 = 1;
        zero_after_reset = 0; valid_after_reset = 0; shift_after_reset = 0;
        held_addr = '0; held_data = '0;
        limit = (reset_cyc > 0) ? reset_cyc + 20 : 600;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            start = (c == restart_cyc);
            if (c == restart_cyc) begin
                base_addr = 16'h0055;
                num_rows  = 8'd3;
                raw_mode  = ~mode;
            end
            reset = (c == reset_cyc);
            if (c == reset_cyc) exp_q.delete();
            case (ready_mode)
                0:       wr_if.wr_ready = 1'b1;
                1:       wr_if.wr_ready = !(c >= 5 && c <= 10);
                2:       wr_if.wr_ready = ($urandom_range(0, 3) != 0);
                default: wr_if.wr_ready = 1'b0;
            endcase
            #2;
            if (c == 1) begin
                busy1  = busy;
                shift1 = shift_en;
            end
            if (c == 8) shift8 = shift_en;
            if (reset_cyc > 0 && c == reset_cyc + 1)
                zero_after_reset = !(shift_en || wr_if.wr_valid || busy || done) &&
                                   row_sel == 8'd0 && wr_if.wr_addr == '0 && wr_if.wr_data == '0;
            if (reset_cyc > 0 && c > reset_cyc) begin
                if (wr_if.wr_valid) valid_after_reset = 1;
                if (shift_en) shift_after_reset = 1;
            end
            if (shift_en) begin
                if (shift_seen) gap_cnt += low_run;
                low_run    = 0;
                shift_seen = 1;
            end else if (shift_seen) begin
                low_run++;
            end
            if (wr_if.wr_valid) begin
                valid_seen = 1;
                if (first_valid_cyc < 0) first_valid_cyc = c;
            end
            if (holding && (wr_if.wr_addr != held_addr || wr_if.wr_data != held_data)) unstable = 1;
            holding   = wr_if.wr_valid && !wr_if.wr_ready;
            held_addr = wr_if.wr_addr;
            held_data = wr_if.wr_data;
            if (done) done_cyc = c;
            if (done_cyc >= 0) break;
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            wr_if.wr_ready = 1'b1;
        end
        #2;
    endtask

    initial begin
        int w0;
        reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; raw_mode = 1'b0;
        wr_if.wr_ready = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int p = 0; p < NUM_PE; p++) row_vals[r][p] = '0;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("reset_shift_en", 32'(shift_en), 0);
        checkOutput("reset_wr_valid", 32'(wr_if.wr_valid), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_row_sel", 32'(row_sel), 0);
        checkOutput("reset_wr_addr", 32'(wr_if.wr_addr), 0);
        checkOutput("reset_wr_data", wr_if.wr_data, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] packed single row");
        for (int p = 0; p < NUM_PE; p++) row_vals[0][p] = 32'(p + 1);
        w0 = n_writes;
        run_drain(1'b0, 8'd1, 16'h0010, 0, 0, 0);
        checkOutput("s1_busy_cycle1", 32'(busy1), 1);
        checkOutput("s1_shift_cycle1", 32'(shift1), 1);
        checkOutput("s1_first_valid_cycle", 32'(first_valid_cyc), 5);
        checkOutput("s1_done_cycle", 32'(done_cyc), 10);
        checkOutput("s1_write_count", 32'(n_writes - w0), 2);
        checkOutput("s1_idle_wr_addr", 32'(wr_if.wr_addr), 0);
        checkOutput("s1_idle_wr_data", wr_if.wr_data, 0);
        checkOutput("s1_idle_row_sel", 32'(row_sel), 0);

        $display("[TB] raw two rows");
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NUM_PE; p++) row_vals[r][p] = $urandom;
        w0 = n_writes;
        run_drain(1'b1, 8'd2, 16'h0000, 0, 0, 0);
        checkOutput("s2_gap_cycles", 32'(gap_cnt), 1);
        checkOutput("s2_write_count", 32'(n_writes - w0), 16);
        checkOutput("s2_done_seen", 32'(done_cyc >= 0), 1);

        $display("[TB] packed with backpressure");
        for (int p = 0; p < NUM_PE; p++) row_vals[0][p] = 32'(p + 1);
        w0 = n_writes;
        run_drain(1'b0, 8'd1, 16'h0010, 1, 0, 0);
        checkOutput("s3_shift_en_stalled", 32'(shift8), 0);
        checkOutput("s3_data_unstable", 32'(unstable), 0);
        checkOutput("s3_done_cycle", 32'(done_cyc), 13);
        checkOutput("s3_write_count", 32'(n_writes - w0), 2);

        $display("[TB] zero rows");
        run_drain(1'b0, 8'd0, 16'h1234, 0, 0, 0);
        checkOutput("s4_done_cycle", 32'(done_cyc), 2);
        checkOutput("s4_shift_seen", 32'(shift_seen), 0);
        checkOutput("s4_valid_seen", 32'(valid_seen), 0);

        $display("[TB] start during drain");
        w0 = n_writes;
        run_drain(1'b0, 8'd1, 16'h0010, 0, 3, 0);
        checkOutput("s5_done_cycle", 32'(done_cyc), 10);
        checkOutput("s5_write_count", 32'(n_writes - w0), 2);
        checkOutput("s5_busy_after", 32'(busy), 0);

        $display("[TB] reset mid row");
        w0 = n_writes;
        run_drain(1'b0, 8'd2, 16'h0010, 3, 0, 5);
        checkOutput("s6_outputs_zero", 32'(zero_after_reset), 1);
        checkOutput("s6_valid_after_reset", 32'(valid_after_reset), 0);
        checkOutput("s6_shift_after_reset", 32'(shift_after_reset), 0);
        checkOutput("s6_write_count", 32'(n_writes - w0), 0);

        $display("[TB] randomized drains");
        for (int i = 0; i < 25; i++) begin
            bit            m;
            logic [7:0]    rows;
            logic [AW-1:0] base;
            m    = 1'($urandom_range(0, 1));
            rows = 8'($urandom_range(0, 4));
            base = ($urandom_range(0, 3) == 0) ? 16'hFFFA : 16'($urandom);
            for (int r = 0; r < 4; r++)
                for (int p = 0; p < NUM_PE; p++) row_vals[r][p] = $urandom;
            run_drain(m, rows, base, 2, 0, 0);
            checkOutput("rand_done_seen", 32'(done_cyc >= 0), 1);
            checkOutput("rand_pending_writes", 32'(exp_q.size()), 0);
        end

        checkOutput("final_pending_writes", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
